// File: rtl/keyboard_writer.sv
// keyboard_writer: PS/2 host-to-device byte transmitter with bus inhibit, ACK check and watchdog.
module keyboard_writer #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] txData,
  input  logic       txStart,
  input  logic       ps2CLK,
  input  logic       ps2DATA,
  output logic       ps2ClkLow,
  output logic       ps2DataLow,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       ackError
);
  localparam int MAXC = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_END = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_END = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE} state_t;
  state_t r_state, w_state;
  logic [2:0] r_clk_sync;
  logic [1:0] r_dat_sync;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [3:0] r_idx, w_idx;
  logic [7:0] r_data, w_data;
  logic r_par, w_par, r_clk_low, w_clk_low, r_data_low, w_data_low;
  logic r_busy, w_busy, r_done, w_done, r_error, w_error, r_ack_error, w_ack_error;
  logic w_fall, w_watch;
  assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_watch = r_state == SEND || r_state == ACK || r_state == WAIT_IDLE;
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt + 1'b1;
    w_idx = r_idx;
    w_data = r_data;
    w_par = r_par;
    w_clk_low = r_clk_low;
    w_data_low = r_data_low;
    w_busy = r_busy;
    w_done = 1'b0;
    w_error = 1'b0;
    w_ack_error = r_ack_error;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        if (txStart) begin
          w_state = INHIBIT;
          w_data = txData;
          w_par = ~^txData;
          w_clk_low = 1'b1;
          w_busy = 1'b1;
          w_ack_error = 1'b0;
        end
      end
      INHIBIT: if (r_cnt == INH_END) begin
        w_state = START;
        w_data_low = 1'b1;
      end
      START: begin
        w_state = SEND;
        w_clk_low = 1'b0;
        w_cnt = '0;
        w_idx = '0;
      end
      SEND: if (w_fall) begin
        w_cnt = '0;
        w_idx = r_idx + 1'b1;
        w_data_low = r_idx < 4'd8 ? ~r_data[r_idx[2:0]] : r_idx == 4'd8 ? ~r_par : 1'b0;
        w_state = r_idx == 4'd9 ? ACK : SEND;
      end
      ACK: if (w_fall) begin
        w_cnt = '0;
        w_state = r_dat_sync[1] ? IDLE : WAIT_IDLE;
        w_error = r_dat_sync[1];
        w_ack_error = r_dat_sync[1];
        w_busy = ~r_dat_sync[1];
        w_data_low = 1'b0;
      end
      WAIT_IDLE: if (w_fall) w_cnt = '0;
      else if (r_clk_sync[1] && r_dat_sync[1]) begin
        w_state = IDLE;
        w_done = 1'b1;
        w_busy = 1'b0;
        w_data_low = 1'b0;
      end
      default: w_state = IDLE;
    endcase
    // an edge on the expiry cycle reloads the counter instead of timing out
    if (w_watch && !w_fall && !w_done && r_cnt == TO_END) begin
      w_state = IDLE;
      w_error = 1'b1;
      w_ack_error = 1'b0;
      w_clk_low = 1'b0;
      w_data_low = 1'b0;
      w_busy = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_cnt <= '0;
      r_idx <= '0;
      r_data <= '0;
      r_par <= 1'b0;
      r_clk_low <= 1'b0;
      r_data_low <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_error <= 1'b0;
      r_ack_error <= 1'b0;
    end else begin
      r_state <= w_state;
      r_clk_sync <= {r_clk_sync[1:0], ps2CLK};
      r_dat_sync <= {r_dat_sync[0], ps2DATA};
      r_cnt <= w_cnt;
      r_idx <= w_idx;
      r_data <= w_data;
      r_par <= w_par;
      r_clk_low <= w_clk_low;
      r_data_low <= w_data_low;
      r_busy <= w_busy;
      r_done <= w_done;
      r_error <= w_error;
      r_ack_error <= w_ack_error;
    end
  end
  assign ps2ClkLow = r_clk_low;
  assign ps2DataLow = r_data_low;
  assign busy = r_busy;
  assign done = r_done;
  assign error = r_error;
  assign ackError = r_ack_error;
endmodule

// File: tb/tb_keyboard_writer.sv
// tb_keyboard_writer: randomized PS/2 device model checking frames, ACK/NACK, watchdog and reset.
module tb_keyboard_writer;
  localparam int INH = 50;
  localparam int TO = 400;
  logic clk = 1'b0, rst = 1'b1, tx_start = 1'b0, dev_clk = 1'b1, dev_data = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic ps2_clk_low, ps2_data_low, busy, done, error, ack_error, bus_clk, bus_data;
  int checks = 0, failures = 0, n_done = 0, n_error = 0, n_both = 0;
  assign bus_clk = dev_clk & ~ps2_clk_low;
  assign bus_data = dev_data & ~ps2_data_low;
  always #5 clk = ~clk;
  keyboard_writer #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .txData(tx_data), .txStart(tx_start), .ps2CLK(bus_clk), .ps2DATA(bus_data),
    .ps2ClkLow(ps2_clk_low), .ps2DataLow(ps2_data_low), .busy(busy), .done(done), .error(error),
    .ackError(ack_error)
  );
  always @(negedge clk) begin
    if (done) n_done++;
    if (error) n_error++;
    if (done && error) n_both++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_tx(input logic [7:0] d);
    cyc(1);
    tx_data = d;
    tx_start = 1'b1;
    cyc(1);
    tx_start = 1'b0;
  endtask

  task automatic wait_release(output int lowc, output int dl, output bit rel);
    lowc = 0;
    dl = 0;
    rel = 0;
    for (int i = 0; i < INH + 100; i++) begin
      @(negedge clk);
      if (!ps2_clk_low) begin
        rel = 1;
        break;
      end
      lowc++;
      if (ps2_data_low) dl++;
    end
  endtask

  task automatic device(input bit nack, input int half, output logic [9:0] bits);
    for (int k = 0; k < 10; k++) begin
      cyc(half);
      dev_clk = 1'b0;
      cyc(half);
      bits[k] = bus_data;
      dev_clk = 1'b1;
    end
    cyc(half);
    dev_data = nack;
    cyc(2);
    dev_clk = 1'b0;
    cyc(half);
    dev_clk = 1'b1;
    dev_data = 1'b1;
  endtask

  task automatic test_reset;
    cyc(3);
    @(negedge clk);
    checks++;
    if ({ps2_clk_low, ps2_data_low, busy, done, error, ack_error} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 000000", {ps2_clk_low, ps2_data_low, busy, done, error, ack_error});
    end
    rst = 1'b0;
    cyc(3);
    checks++;
    if ({ps2_clk_low, ps2_data_low, busy} !== 3'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got %b expected 000", {ps2_clk_low, ps2_data_low, busy});
    end
  endtask

  task automatic test_transfer(input logic [7:0] d, input bit nack, input int half, input bit extra);
    int lowc, dl, d0, e0;
    bit rel;
    logic [9:0] bits, exp;
    exp = {1'b1, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0, d};
    d0 = n_done;
    e0 = n_error;
    start_tx(d);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_start: got %b expected 1", busy);
    end
    if (extra) begin
      cyc(3);
      tx_data = 8'h55;
      tx_start = 1'b1;
      cyc(1);
      tx_start = 1'b0;
    end
    wait_release(lowc, dl, rel);
    checks++;
    if (!rel) begin
      failures++;
      $display("FAIL clock_release: got held expected released");
    end
    if (!extra) begin
      checks++;
      if (lowc !== INH + 1 || dl !== 1) begin
        failures++;
        $display("FAIL inhibit_len: got low=%0d start=%0d expected low=%0d start=1", lowc, dl, INH + 1);
      end
    end
    checks++;
    if (bus_data !== 1'b0) begin
      failures++;
      $display("FAIL start_bit: got %b expected 0", bus_data);
    end
    device(nack, half, bits);
    cyc(10);
    checks++;
    if (bits !== exp) begin
      failures++;
      $display("FAIL frame_%h: got %b expected %b", d, bits, exp);
    end
    checks++;
    if ((n_done - d0) !== (nack ? 0 : 1) || (n_error - e0) !== (nack ? 1 : 0) || ack_error !== nack) begin
      failures++;
      $display("FAIL result_%h: got done=%0d err=%0d ack=%b expected nack=%b", d, n_done - d0, n_error - e0, ack_error, nack);
    end
    checks++;
    if ({busy, ps2_clk_low, ps2_data_low} !== 3'b0) begin
      failures++;
      $display("FAIL released_%h: got %b expected 000", d, {busy, ps2_clk_low, ps2_data_low});
    end
  endtask

  task automatic test_timeout;
    int lowc, dl, n, e0;
    bit rel;
    e0 = n_error;
    n = 0;
    start_tx(8'hA7);
    wait_release(lowc, dl, rel);
    for (int i = 1; i <= TO + 50; i++) begin
      cyc(1);
      if (error) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n !== TO) begin
      failures++;
      $display("FAIL timeout_delay: got %0d expected %0d", n, TO);
    end
    cyc(2);
    checks++;
    if (ack_error !== 1'b0 || busy !== 1'b0 || (n_error - e0) !== 1 || ps2_clk_low !== 1'b0 || ps2_data_low !== 1'b0) begin
      failures++;
      $display("FAIL timeout_state: got ack=%b busy=%b errs=%0d expected ack=0 busy=0 errs=1", ack_error, busy, n_error - e0);
    end
  endtask

  task automatic test_reset_mid_send;
    int lowc, dl, d0, e0;
    bit rel;
    start_tx(8'hED);
    wait_release(lowc, dl, rel);
    for (int k = 0; k < 5; k++) begin
      cyc(15);
      dev_clk = 1'b0;
      cyc(15);
      dev_clk = 1'b1;
    end
    cyc(1);
    checks++;
    if (busy !== 1'b1 || ps2_data_low !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: got busy=%b dlow=%b expected 1 1", busy, ps2_data_low);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ps2_clk_low, ps2_data_low, busy} !== 3'b0) begin
      failures++;
      $display("FAIL async_reset: got %b expected 000", {ps2_clk_low, ps2_data_low, busy});
    end
    d0 = n_done;
    e0 = n_error;
    cyc(2);
    rst = 1'b0;
    cyc(TO + 20);
    checks++;
    if (n_done !== d0 || n_error !== e0) begin
      failures++;
      $display("FAIL post_reset_pulse: got done=%0d err=%0d expected 0 0", n_done - d0, n_error - e0);
    end
  endtask

  initial begin
    test_reset;
    test_transfer(8'hED, 1'b0, 20, 1'b0);
    test_transfer(8'hF4, 1'b0, 20, 1'b0);
    test_transfer(8'h00, 1'b0, 20, 1'b0);
    for (int i = 0; i < 5; i++) test_transfer(8'($urandom), 1'b0, $urandom_range(10, 40), 1'b0);
    test_transfer(8'($urandom), 1'b1, $urandom_range(10, 40), 1'b0);
    test_timeout;
    test_reset_mid_send;
    test_transfer(8'hED, 1'b0, 20, 1'b0);
    test_transfer(8'hED, 1'b0, 20, 1'b1);
    test_transfer(8'($urandom), 1'b0, $urandom_range(10, 40), 1'b0);
    checks++;
    if (n_both !== 0) begin
      failures++;
      $display("FAIL done_and_error: got %0d overlaps expected 0", n_both);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
